// File: rtl/fns_dec_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fns_dec_serial
// Description : Bit-serial Fibonacci-numeral-system codeword decoder with
//               forbidden-pattern (FPF) detection and valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module fns_dec_serial #(
    parameter int CW = 16,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] codein,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dataout,
    output logic          fpf_err
);

    localparam int              c_cnt_w   = $clog2(CW);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CW - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Standard Fibonacci number F(n) with F(1)=F(2)=1, for the width check.
    function automatic logic [63:0] fib(input int n);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] t;
        a = 64'd1;
        b = 64'd1;
        for (int i = 3; i <= n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    generate
        if ((64'd1 << DW) < fib(CW + 2)) begin : g_dw_check
            $error("fns_dec_serial: DW too small for CW");
        end
    endgenerate

    function automatic logic fpf_check(input logic [CW-1:0] w);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < CW - 2; i++) begin
            if (w[i +: 3] == 3'b010 || w[i +: 3] == 3'b101) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CW-1:0]      r_sr;
    logic [DW-1:0]      r_acc;
    logic [DW-1:0]      r_wa;
    logic [DW-1:0]      r_wb;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;
    logic               w_accept;

    assign w_accept = in_valid && (r_state == c_st_idle);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (in_valid)        w_state_nxt = c_st_run;
            c_st_run:  if (r_cnt == c_last) w_state_nxt = c_st_done;
            c_st_done: if (out_ready)       w_state_nxt = c_st_idle;
            default:                        w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_st_idle);
        out_valid = (r_state == c_st_done);
        dataout   = out_valid ? r_acc : '0;
        fpf_err   = out_valid ? r_err : 1'b0;
    end

    // Weights W(k) are produced on the fly: wa holds the current weight,
    // wb the next one, so each RUN cycle advances the Fibonacci pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr  <= '0;
            r_acc <= '0;
            r_wa  <= '0;
            r_wb  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_sr  <= codein;
            r_acc <= '0;
            r_wa  <= DW'(1);
            r_wb  <= DW'(1);
            r_cnt <= '0;
            r_err <= fpf_check(codein);
        end else if (r_state == c_st_run) begin
            if (r_sr[0]) begin
                r_acc <= r_acc + r_wa;
            end
            r_sr  <= r_sr >> 1;
            r_wa  <= r_wb;
            r_wb  <= r_wa + r_wb;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire
